// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect
// handling and static beq prediction selected by bp_mode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bp_mode,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        ifid_pred_taken
);

  typedef enum logic [1:0] {
    BP_NOT_TAKEN = 2'b00,
    BP_TAKEN     = 2'b01,
    BP_DELAY     = 2'b10,
    BP_RESERVED  = 2'b11
  } bp_mode_e;

  localparam logic [5:0] OPC_BEQ = 6'b000100;

  bp_mode_e    mode;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        pred_q, pred_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic        is_beq;

  assign mode      = bp_mode_e'(bp_mode);
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign is_beq    = (imem_rdata[31:26] == OPC_BEQ);

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    if (!stall) begin
      pc_d    = pc_plus4;
      ir_d    = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      pred_d  = 1'b0;
      if (redirect) begin
        pc_d = redirect_target;
        // In delay-slot mode the word fetched alongside the redirect is kept.
        if (mode != BP_DELAY) begin
          ir_d    = NOP_WORD;
          valid_d = 1'b0;
          pred_d  = 1'b0;
        end
      end else if (mode == BP_TAKEN && is_beq) begin
        pc_d   = br_target;
        pred_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      pred_q  <= pred_d;
    end
  end

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign ifid_ir         = ir_q;
  assign ifid_pc4        = pc4_q;
  assign ifid_valid      = valid_q;
  assign ifid_pred_taken = pred_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF state per edge,
// a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bp_mode;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        ifid_pred_taken;

  logic [31:0] imem [0:63];
  assign imem_rdata = imem[imem_addr[7:2]];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bp_mode(bp_mode),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .pc(pc), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .ifid_pred_taken(ifid_pred_taken)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        valid;
    logic        pred;
    logic        chk_pc4;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cur_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".imem_addr"}, imem_addr, e.pc);
      chk({e.name, ".ir"}, ifid_ir, e.ir);
      if (e.chk_pc4) chk({e.name, ".pc4"}, ifid_pc4, e.pc4);
      chk({e.name, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({e.name, ".pred"}, {31'd0, ifid_pred_taken}, {31'd0, e.pred});
    end
  end

  function automatic exp_t mk(input string n, input logic [31:0] p, input logic [31:0] ir,
                              input logic [31:0] p4, input logic v, input logic pr,
                              input logic c4);
    exp_t e;
    e.name = n; e.pc = p; e.ir = ir; e.pc4 = p4; e.valid = v; e.pred = pr; e.chk_pc4 = c4;
    return e;
  endfunction

  task automatic step(input exp_t e);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Sequential fetch with no stall/redirect/beq in the fetched word.
  task automatic adv(input string n, input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      step(mk(n, cur_pc + 32'd4, imem[cur_pc[7:2]], cur_pc + 32'd4, 1'b1, 1'b0, 1'b1));
      cur_pc = cur_pc + 32'd4;
    end
  endtask

  task automatic do_reset(input logic [1:0] mode);
    rst = 1'b0; bp_mode = mode; stall = 1'b0; redirect = 1'b0;
    step(mk("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    rst = 1'b1;
    cur_pc = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + 32'(i);
    imem[15] = 32'h1180_0002;  // beq at 0x3C, offset +2 words
    rst = 1'b0; bp_mode = 2'b00; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0120;

    // 1: reset dominates stall and redirect
    step(mk("rst1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    step(mk("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    cur_pc = 32'h0;

    // 2: straight line, mode 00 passes beq without predicting
    adv("seq", 22);
    chk("seq.final_pc", cur_pc, 32'h0000_0058);

    // 3: stall holds, redirect under stall ignored
    do_reset(2'b00);
    adv("pre_stall", 2);
    stall = 1'b1;
    step(mk("stall1", 32'h8, imem[1], 32'h8, 1'b1, 1'b0, 1'b1));
    step(mk("stall2", 32'h8, imem[1], 32'h8, 1'b1, 1'b0, 1'b1));
    redirect = 1'b1; redirect_target = 32'h0000_0050;
    step(mk("stall_redir", 32'h8, imem[1], 32'h8, 1'b1, 1'b0, 1'b1));
    stall = 1'b0; redirect = 1'b0;
    adv("post_stall", 1);

    // 4: mode 00 redirect flushes one bubble
    adv("to_18", 3);
    redirect = 1'b1; redirect_target = 32'h0000_0050;
    step(mk("redir00", 32'h50, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    redirect = 1'b0; cur_pc = 32'h50;
    adv("after_redir00", 1);

    // 5: mode 10 keeps the delay slot
    do_reset(2'b10);
    adv("d_to_18", 6);
    redirect = 1'b1;
    step(mk("redir10", 32'h50, imem[6], 32'h1C, 1'b1, 1'b0, 1'b1));
    redirect = 1'b0; cur_pc = 32'h50;
    adv("after_redir10", 1);

    // 6: mode 01 predicts beq taken, mispredict repair via redirect
    do_reset(2'b01);
    adv("t_to_3c", 15);
    step(mk("beq_pred", 32'h48, 32'h1180_0002, 32'h40, 1'b1, 1'b1, 1'b1));
    redirect = 1'b1; redirect_target = 32'h0000_0044;
    step(mk("mispred", 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    redirect = 1'b0; cur_pc = 32'h44;
    adv("after_mispred", 1);
    do_reset(2'b00);
    adv("n_to_3c", 15);
    step(mk("beq_nt", 32'h40, 32'h1180_0002, 32'h40, 1'b1, 1'b0, 1'b1));

    // reserved mode behaves as not-taken
    do_reset(2'b11);
    adv("r_to_3c", 15);
    step(mk("beq_rsvd", 32'h40, 32'h1180_0002, 32'h40, 1'b1, 1'b0, 1'b1));

    // misaligned target passes through; PC wraps past 2^32
    redirect = 1'b1; redirect_target = 32'h0000_0102;
    step(mk("misalign", 32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    redirect_target = 32'hFFFF_FFFC;
    step(mk("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    redirect = 1'b0;
    step(mk("wrap", 32'h0, imem[63], 32'h0, 1'b1, 1'b0, 1'b1));

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
